serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer for the ALU arithmetic path.
- Time-shares one 1-bit full adder (add1: a, b, carry_in -> out, carry_out) across WIDTH clock cycles, LSB first.
- Produces a WIDTH-bit result with carry and signed-overflow flags.
- Uses a start/busy/done handshake so a higher-level ALU controller can issue operations.

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle between an ALU controller (master)
// and the bit-serial add/subtract sequencer (slave).
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit full adder is reused for WIDTH
// cycles, LSB first, yielding a WIDTH-bit result plus carry and signed overflow.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             add_out;
    logic             add_co;
    logic             c_msb_in;
    logic [WIDTH-1:0] sum_shifted;

    // The single shared 1-bit full adder: returns {carry_out, out}.
    function automatic logic [1:0] add1(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    always_comb begin
        {add_co, add_out} = add1(a_sr_q[0], b_sr_q[0], c_q);
        sum_shifted       = {add_out, s_sr_q[WIDTH-1:1]};
        c_msb_in          = c_q;
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        s_sr_d   = s_sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtraction runs as A + ~B + 1, the +1 entering as the initial carry.
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.op ? ~bus.b : bus.b;
                    c_d     = bus.op;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s_sr_d = sum_shifted;
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = add_co;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    result_d = sum_shifted;
                    carry_d  = add_co;
                    ovf_d    = c_msb_in ^ add_co;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy/done are registered copies decoded from the next state.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            s_sr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            s_sr_q   <= s_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=4 with hand-computed expectations.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(4)) bus ();

    serial_add_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Issues one operation in IDLE, scrambles the inputs after acceptance and
    // waits (bounded) for done. Returns at the negedge inside the done cycle.
    task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic opi,
                         output int busy_n, output logic got,
                         output logic [3:0] r, output logic c, output logic v);
        busy_n = 0;
        got    = 1'b0;
        r      = 'x;
        c      = 1'bx;
        v      = 1'bx;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ai;
        bus.b     = bi;
        bus.op    = opi;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~ai;
        bus.b     = ~bi;
        bus.op    = ~opi;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.done) begin
                got = 1'b1;
                r   = bus.result;
                c   = bus.carry_out;
                v   = bus.overflow;
            end else begin
                if (bus.busy) busy_n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 4'h3;
        bus.b     = 4'h5;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%b c=%b v=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_start: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_add_overflow();
        int busy_n; logic got; logic [3:0] r; logic c, v;
        do_op(4'b0011, 4'b0101, 1'b0, busy_n, got, r, c, v);
        total++;
        if (got !== 1'b1) begin
            bad++;
            $display("FAIL add_ovf_done_timeout: got=%b, want 1", got);
        end
        total++;
        if (busy_n != 4) begin
            bad++;
            $display("FAIL add_ovf_busy_cycles: got %0d, want 4", busy_n);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL add_ovf_busy_with_done: busy=%b, want 0", bus.busy);
        end
        total++;
        if ({r, c, v} !== {4'b1000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_ovf_result: got r=%b c=%b v=%b, want r=1000 c=0 v=1", r, c, v);
        end
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL add_ovf_done_width: done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
        total++;
        if ({bus.result, bus.carry_out, bus.overflow} !== {4'b1000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_ovf_hold: got r=%b c=%b v=%b, want 1000 0 1",
                     bus.result, bus.carry_out, bus.overflow);
        end
    endtask

    task automatic test_add_wrap();
        int busy_n; logic got; logic [3:0] r; logic c, v;
        do_op(4'b1111, 4'b0001, 1'b0, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL add_wrap_1: got done=%b r=%b c=%b v=%b, want 1 0000 1 0", got, r, c, v);
        end
        do_op(4'b0111, 4'b0111, 1'b0, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b1110, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_wrap_2: got done=%b r=%b c=%b v=%b, want 1 1110 0 1", got, r, c, v);
        end
    endtask

    task automatic test_subtract();
        int busy_n; logic got; logic [3:0] r; logic c, v;
        do_op(4'b0101, 4'b0011, 1'b1, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b0010, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_1: got done=%b r=%b c=%b v=%b, want 1 0010 1 0", got, r, c, v);
        end
        do_op(4'b0011, 4'b0101, 1'b1, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b1110, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sub_2: got done=%b r=%b c=%b v=%b, want 1 1110 0 0", got, r, c, v);
        end
        do_op(4'b1000, 4'b0001, 1'b1, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b0111, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sub_3: got done=%b r=%b c=%b v=%b, want 1 0111 1 1", got, r, c, v);
        end
    endtask

    task automatic test_start_ignored();
        int busy_n; logic got; logic [3:0] r; logic c, v;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b0011; bus.b = 4'b0101; bus.op = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        // Previous result (0111 from the last subtract) must be untouched during RUN.
        total++;
        if ({bus.busy, bus.result} !== {1'b1, 4'b0111}) begin
            bad++;
            $display("FAIL run_hold: busy=%b result=%b, want 1 0111", bus.busy, bus.result);
        end
        bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b1111; bus.op = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else @(negedge clk);
        end
        total++;
        if ({got, bus.result, bus.carry_out, bus.overflow} !== {1'b1, 4'b1000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL start_in_run: got done=%b r=%b c=%b v=%b, want 1 1000 0 1",
                     got, bus.result, bus.carry_out, bus.overflow);
        end
        bus.start = 1'b1; bus.a = 4'b0001; bus.b = 4'b0001; bus.op = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.result} !== {1'b0, 1'b0, 4'b1000}) begin
            bad++;
            $display("FAIL start_in_done: busy=%b done=%b result=%b, want 0 0 1000",
                     bus.busy, bus.done, bus.result);
        end
        do_op(4'b0001, 4'b0001, 1'b0, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b0010, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL start_after_idle: got done=%b r=%b c=%b v=%b, want 1 0010 0 0", got, r, c, v);
        end
    endtask

    task automatic test_reset_mid_op();
        int busy_n; logic got; logic [3:0] r; logic c, v; logic saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b0111; bus.b = 4'b0111; bus.op = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow} !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b r=%b c=%b v=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done: activity=%b, want 0", saw_done);
        end
        do_op(4'b0010, 4'b0010, 1'b0, busy_n, got, r, c, v);
        total++;
        if ({got, r, c, v} !== {1'b1, 4'b0100, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_fresh: got done=%b r=%b c=%b v=%b, want 1 0100 0 0", got, r, c, v);
        end
    endtask

    task automatic test_sweep();
        int busy_n; logic got; logic [3:0] r; logic c, v;
        int ua, ub, ures, sa, sb, sres;
        logic [3:0] er; logic ec, ev;
        for (int o = 0; o < 2; o++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    do_op(4'(ia), 4'(ib), o[0], busy_n, got, r, c, v);
                    ua = ia; ub = ib;
                    sa = (ia > 7) ? ia - 16 : ia;
                    sb = (ib > 7) ? ib - 16 : ib;
                    if (o == 0) begin
                        ures = ua + ub;
                        ec   = (ures > 15);
                        sres = sa + sb;
                    end else begin
                        ures = ua - ub;
                        ec   = (ua >= ub);
                        sres = sa - sb;
                    end
                    er = 4'(ures);
                    ev = (sres > 7) || (sres < -8);
                    total++;
                    if ({got, r, c, v} !== {1'b1, er, ec, ev}) begin
                        bad++;
                        $display("FAIL sweep op=%0d a=%0d b=%0d: got done=%b r=%b c=%b v=%b, want 1 %b %b %b",
                                 o, ia, ib, got, r, c, v, er, ec, ev);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_add_overflow();
        test_add_wrap();
        test_subtract();
        test_start_ignored();
        test_reset_mid_op();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
